// File: rtl/inst_seq_pkg.sv
// inst_seq_pkg: shared types and constants for the instruction sequencer.
//   state_t    : sequencer state encoding
//   Q1..Q4     : q_phase values within one four-clock instruction cycle
//   OP_* / INST_* : opcode match fields and full-word instructions
//   is_branch / is_skip_op / uses_imm : opcode class decoders on the IR word
package inst_seq_pkg;

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_EXEC    = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_SLEEP   = 2'd3
  } state_t;

  localparam logic [1:0] Q1 = 2'd0;
  localparam logic [1:0] Q2 = 2'd1;
  localparam logic [1:0] Q3 = 2'd2;
  localparam logic [1:0] Q4 = 2'd3;

  // Match fields, compared against the top bits of the instruction word
  localparam logic [2:0]  OP_GOTO   = 3'b101;     // inst[11:9]
  localparam logic [3:0]  OP_CALL   = 4'b1001;    // inst[11:8]
  localparam logic [3:0]  OP_RETLW  = 4'b1000;    // inst[11:8]
  localparam logic [1:0]  OP_LIT    = 2'b11;      // inst[11:10]
  localparam logic [3:0]  OP_BTFSC  = 4'b0110;    // inst[11:8]
  localparam logic [3:0]  OP_BTFSS  = 4'b0111;    // inst[11:8]
  localparam logic [5:0]  OP_DECFSZ = 6'b001011;  // inst[11:6]
  localparam logic [5:0]  OP_INCFSZ = 6'b001111;  // inst[11:6]
  localparam logic [11:0] INST_SLEEP = 12'h003;
  localparam logic [11:0] INST_NOP   = 12'h000;

  // Instructions that redirect the PC and make the prefetched word stale
  function automatic logic is_branch(input logic [11:0] inst);
    return (inst[11:9] == OP_GOTO) || (inst[11:8] == OP_CALL) ||
           (inst[11:8] == OP_RETLW);
  endfunction

  function automatic logic is_skip_op(input logic [11:0] inst);
    return (inst[11:8] == OP_BTFSC) || (inst[11:8] == OP_BTFSS) ||
           (inst[11:6] == OP_DECFSZ) || (inst[11:6] == OP_INCFSZ);
  endfunction

  // Instructions whose literal field is driven onto the immediate bus
  function automatic logic uses_imm(input logic [11:0] inst);
    return (inst[11:8] == OP_RETLW) || (inst[11:8] == OP_CALL) ||
           (inst[11:10] == OP_LIT);
  endfunction

endpackage

// File: rtl/inst_seq_ctrl_if.sv
// inst_seq_ctrl_if: bundle between the core datapath and the sequencer.
//   inst, skip_cond, wake     : core -> sequencer
//   q_phase, pc_inc, pc_load, imm_oe, ir_skip, ir_hold, sleeping : sequencer -> core
// Modports: master = core datapath side, slave = sequencer side.
interface inst_seq_ctrl_if;

  logic [11:0] inst;
  logic        skip_cond;
  logic        wake;
  logic [1:0]  q_phase;
  logic        pc_inc;
  logic        pc_load;
  logic        imm_oe;
  logic        ir_skip;
  logic        ir_hold;
  logic        sleeping;

  modport master (
    output inst, skip_cond, wake,
    input  q_phase, pc_inc, pc_load, imm_oe, ir_skip, ir_hold, sleeping
  );

  modport slave (
    input  inst, skip_cond, wake,
    output q_phase, pc_inc, pc_load, imm_oe, ir_skip, ir_hold, sleeping
  );

endinterface

// File: rtl/inst_seq_ctrl_q_phase_gen.sv
// q_phase_gen: free-running 2-bit Q-phase counter (Q1..Q4).
//   clock   : rising-edge clock
//   reset   : asynchronous, active-high; forces Q1
//   hold    : freezes the phase while high
//   q_phase : current phase
module q_phase_gen
  import inst_seq_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       hold,
  output logic [1:0] q_phase
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_phase <= Q1;
    end else if (!hold) begin
      q_phase <= q_phase + 2'd1;
    end
  end

endmodule

// File: rtl/inst_seq_ctrl.sv
// inst_seq_ctrl: four-phase instruction sequencer for a 12-bit core.
// Generates the per-phase PC/IR strobes, flushes the prefetched word after
// branches and taken skips, and forces NOPs for STARTUP_CYCLES cycles out of
// reset.
//   clock : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : inst_seq_ctrl_if.slave (inst, skip_cond, wake in;
//           q_phase, pc_inc, pc_load, imm_oe, ir_skip, ir_hold, sleeping out)
// Parameter STARTUP_CYCLES: instruction cycles of forced NOP after reset.
// Build macro INST_SEQ_CTRL_SLEEP_EN: enables the SLEEP instruction and the
// wake path; when undefined SLEEP decodes as NOP and sleeping is tied low.
//
// state   | meaning
// --------+-------------------------------------------------------------
// STARTUP | post-reset cycles; IR flushed to NOP at every Q4
// EXEC    | normal decode of the IR contents
// FLUSH   | executes the NOP that replaced a stale prefetch; no decode
// SLEEP   | phase frozen at Q1, strobes idle, waiting for wake
module inst_seq_ctrl
  import inst_seq_pkg::*;
#(
  parameter int STARTUP_CYCLES = 1
) (
  input  logic           clock,
  input  logic           reset,
  inst_seq_ctrl_if.slave bus
);

  localparam int CNT_W = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((STARTUP_CYCLES > 0) ? STARTUP_CYCLES - 1 : 0);

  state_t           state_q, next_state;
  logic [CNT_W-1:0] start_cnt_q, start_cnt_d;
  logic             skip_q;
  logic [1:0]       q_phase;
  logic             phase_hold;
  logic             pc_inc, pc_load, imm_oe, ir_skip, ir_hold, sleep_o;

  q_phase_gen u_q_phase_gen (
    .clock   (clock),
    .reset   (reset),
    .hold    (phase_hold),
    .q_phase (q_phase)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_STARTUP;
      start_cnt_q <= '0;
      skip_q      <= 1'b0;
    end else begin
      state_q     <= next_state;
      start_cnt_q <= start_cnt_d;
      // skip_cond is only valid at Q3; keep that sample for the Q4 decision
      if (q_phase == Q3) begin
        skip_q <= bus.skip_cond;
      end
    end
  end

  always_comb begin
    next_state  = state_q;
    start_cnt_d = start_cnt_q;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    imm_oe      = 1'b0;
    ir_skip     = 1'b0;
    ir_hold     = (q_phase != Q4);
    sleep_o     = 1'b0;
    phase_hold  = 1'b0;

    case (state_q)
      ST_STARTUP: begin
        if (q_phase == Q4) begin
          ir_skip = 1'b1;
          if (start_cnt_q == CNT_LAST) begin
            next_state = ST_EXEC;
          end else begin
            start_cnt_d = start_cnt_q + 1'b1;
          end
        end
      end

      ST_EXEC: begin
        pc_inc = (q_phase == Q1);
        imm_oe = ((q_phase == Q2) || (q_phase == Q3)) && uses_imm(bus.inst);
        if (q_phase == Q4) begin
          if (is_branch(bus.inst)) begin
            pc_load    = 1'b1;
            ir_skip    = 1'b1;
            next_state = ST_FLUSH;
          end else if (is_skip_op(bus.inst) && skip_q) begin
            ir_skip    = 1'b1;
            next_state = ST_FLUSH;
          end
`ifdef INST_SEQ_CTRL_SLEEP_EN
          else if (bus.inst == INST_SLEEP) begin
            next_state = ST_SLEEP;
          end
`endif
        end
      end

      ST_FLUSH: begin
        // The slot holds a NOP: advance the PC, never decode
        pc_inc = (q_phase == Q1);
        if (q_phase == Q4) begin
          next_state = ST_EXEC;
        end
      end

`ifdef INST_SEQ_CTRL_SLEEP_EN
      ST_SLEEP: begin
        // Phase stays at Q1 so the wake edge lands directly on EXEC Q1
        ir_hold    = 1'b1;
        sleep_o    = 1'b1;
        phase_hold = 1'b1;
        if (bus.wake) begin
          next_state = ST_EXEC;
        end
      end
`endif

      default: begin
        next_state = ST_STARTUP;
      end
    endcase
  end

  assign bus.q_phase = q_phase;
  assign bus.pc_inc  = pc_inc;
  assign bus.pc_load = pc_load;
  assign bus.imm_oe  = imm_oe;
  assign bus.ir_skip = ir_skip;
  assign bus.ir_hold = ir_hold;

`ifdef INST_SEQ_CTRL_SLEEP_EN
  assign bus.sleeping = sleep_o;
`else
  // Without the sleep feature wake and the low opcode bits have no consumer
  logic unused_sleep_inputs;
  assign unused_sleep_inputs = ^{bus.wake, bus.inst[5:0], sleep_o};
  assign bus.sleeping        = 1'b0;
`endif

endmodule

// File: tb/tb_inst_seq_ctrl.sv
// tb_inst_seq_ctrl: directed plus randomized bench for inst_seq_ctrl.
// Output vector compared every clock:
//   {q_phase[1:0], pc_inc, pc_load, imm_oe, ir_skip, ir_hold, sleeping}
// Build with INST_SEQ_CTRL_SLEEP_EN defined to exercise the sleep path.
module tb_inst_seq_ctrl;
  import inst_seq_pkg::*;

  localparam int STARTUP_CYCLES = 1;
  localparam int M_STARTUP = 0;
  localparam int M_EXEC    = 1;
  localparam int M_FLUSH   = 2;
  localparam int M_SLEEP   = 3;
  localparam logic [7:0] RESET_VEC = 8'b00_0_0_0_0_1_0;

`ifdef INST_SEQ_CTRL_SLEEP_EN
  localparam bit SLEEP_EN = 1'b1;
`else
  localparam bit SLEEP_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   m_mode;
  int   m_left;

  inst_seq_ctrl_if bus ();

  inst_seq_ctrl #(.STARTUP_CYCLES(STARTUP_CYCLES)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] observed();
    return {bus.q_phase, bus.pc_inc, bus.pc_load, bus.imm_oe,
            bus.ir_skip, bus.ir_hold, bus.sleeping};
  endfunction

  // Reference: one instruction cycle described by opcode class and phase
  function automatic bit m_branch(int mode, logic [11:0] ins);
    int top = int'(ins[11:8]);
    return (mode == M_EXEC) && (top >= 8) && (top <= 11);
  endfunction

  function automatic bit m_skip_taken(int mode, logic [11:0] ins, logic sk);
    int top  = int'(ins[11:8]);
    int top6 = int'(ins[11:6]);
    return (mode == M_EXEC) && sk &&
           ((top == 6) || (top == 7) || (top6 == 11) || (top6 == 15));
  endfunction

  function automatic logic [7:0] model_vec(int mode, int q, logic [11:0] ins, logic sk);
    int top = int'(ins[11:8]);
    bit imm, inc, ld, skp, hold;
    if (mode == M_SLEEP) return 8'b00_0_0_0_0_1_1;
    imm  = (mode == M_EXEC) && ((top == 8) || (top == 9) || (top >= 12)) &&
           ((q == 1) || (q == 2));
    inc  = (mode != M_STARTUP) && (q == 0);
    ld   = m_branch(mode, ins) && (q == 3);
    skp  = (q == 3) && ((mode == M_STARTUP) || m_branch(mode, ins) ||
                        m_skip_taken(mode, ins, sk));
    hold = (q != 3);
    return {2'(q), inc, ld, imm, skp, hold, 1'b0};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    total_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
  endtask

  // Entered at posedge+2 of a Q1 clock; leaves at posedge+2 of the next Q1
  task automatic run_cycle(input logic [11:0] ins, input logic sk, input string tag);
    for (int q = 0; q < 4; q++) begin
      if (q == 0) bus.inst = ins;
      bus.skip_cond = (q == 2) ? sk : 1'($urandom);
      bus.wake      = 1'($urandom);
      #3;
      check($sformatf("%s m%0d q%0d", tag, m_mode, q), observed(),
            model_vec(m_mode, q, ins, sk));
      @(posedge clock);
      #2;
    end
    case (m_mode)
      M_STARTUP: begin
        m_left--;
        if (m_left <= 0) m_mode = M_EXEC;
      end
      M_EXEC: begin
        if (m_branch(m_mode, ins) || m_skip_taken(m_mode, ins, sk)) m_mode = M_FLUSH;
        else if (SLEEP_EN && ins == INST_SLEEP) m_mode = M_SLEEP;
      end
      default: m_mode = M_EXEC;
    endcase
  endtask

  task automatic sleep_wait(input int n);
    for (int i = 0; i < n; i++) begin
      bus.wake = 1'b0;
      bus.skip_cond = 1'($urandom);
      #3;
      check($sformatf("sleep clk%0d", i), observed(), model_vec(M_SLEEP, 0, INST_NOP, 1'b0));
      @(posedge clock);
      #2;
    end
    bus.wake = 1'b1;
    #3;
    check("sleep wake sampled", observed(), model_vec(M_SLEEP, 0, INST_NOP, 1'b0));
    @(posedge clock);
    #2;
    bus.wake = 1'b0;
    m_mode = M_EXEC;
  endtask

  function automatic logic [11:0] pick_inst();
    logic [11:0] r = 12'($urandom);
    case ($urandom_range(0, 7))
      0: return r;
      1: return {3'b101, r[8:0]};
      2: return {4'b1001, r[7:0]};
      3: return {4'b1000, r[7:0]};
      4: return {3'b011, r[8:0]};
      5: return r[11] ? {6'b001011, r[5:0]} : {6'b001111, r[5:0]};
      6: return {2'b11, r[9:0]};
      default: return r[0] ? INST_SLEEP : INST_NOP;
    endcase
  endfunction

  initial begin
    logic [11:0] ins;
    bus.inst = INST_NOP;
    bus.skip_cond = 1'b0;
    bus.wake = 1'b0;

    #12;
    check("reset hold", observed(), RESET_VEC);
    @(posedge clock);
    #2;
    reset = 1'b0;
    m_mode = M_STARTUP;
    m_left = STARTUP_CYCLES;

    // Startup ignores the IR contents
    for (int i = 0; i < STARTUP_CYCLES; i++) run_cycle(12'hA10, 1'b1, "startup");

    run_cycle(12'hC5A, 1'b0, "movlw");
    run_cycle(12'hA10, 1'b0, "goto");
    run_cycle(INST_NOP, 1'b0, "goto flush");
    run_cycle(12'h6E5, 1'b1, "btfsc taken");
    run_cycle(12'hA10, 1'b1, "flushed goto");
    run_cycle(12'h6E5, 1'b0, "btfsc not taken");
    run_cycle(12'h901, 1'b0, "call");
    run_cycle(12'h2C0, 1'b1, "flushed decfsz");
    run_cycle(12'h3C1, 1'b1, "incfsz taken");
    run_cycle(12'h802, 1'b0, "flushed retlw");

    run_cycle(INST_SLEEP, 1'b0, "sleep inst");
    if (m_mode == M_SLEEP) sleep_wait(20);
    run_cycle(12'hC5A, 1'b0, "after sleep");

    for (int i = 0; i < 150; i++) begin
      ins = pick_inst();
      run_cycle(ins, 1'($urandom), "rand");
      if (m_mode == M_SLEEP) sleep_wait($urandom_range(1, 6));
    end

    // Asynchronous reset in the middle of Q3
    bus.inst = INST_NOP;
    for (int q = 0; q < 2; q++) begin
      #3;
      check($sformatf("pre-reset q%0d", q), observed(), model_vec(m_mode, q, INST_NOP, 1'b0));
      @(posedge clock);
      #2;
    end
    #3;
    check("pre-reset q2", observed(), model_vec(m_mode, 2, INST_NOP, 1'b0));
    reset = 1'b1;
    #1;
    check("reset mid-Q3", observed(), RESET_VEC);
    @(posedge clock);
    #2;
    check("reset held over edge", observed(), RESET_VEC);
    reset = 1'b0;
    m_mode = M_STARTUP;
    m_left = STARTUP_CYCLES;
    for (int i = 0; i < STARTUP_CYCLES; i++) run_cycle(12'h901, 1'b1, "restart");
    run_cycle(12'hC5A, 1'b0, "restart exec");
    run_cycle(12'hA10, 1'b0, "restart goto");
    run_cycle(INST_NOP, 1'b0, "restart flush");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/inst_seq_ctrl.md
INST_SEQ_CTRL -- requirements
Module: inst_seq_ctrl

Interface
REQ-001 Parameter STARTUP_CYCLES, default 1: instruction cycles after reset during which the IR is forced to NOP.
REQ-002 clock  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 inst  input  12  current instruction register contents.
REQ-005 skip_cond  input  1  skip-test result from the ALU (BTFSC/BTFSS bit, DECFSZ/INCFSZ zero), valid at Q3.
REQ-006 wake  input  1  wake request; level-sensitive; meaningful only while sleeping.
REQ-007 q_phase  output  2  current phase (0=Q1 .. 3=Q4).
REQ-008 pc_inc  output  1  PC increment strobe.
REQ-009 pc_load  output  1  PC load strobe for GOTO/CALL/RETLW.
REQ-010 imm_oe  output  1  immediate-bus output enable to the IR.
REQ-011 ir_skip  output  1  IR flush strobe, which loads NOP (12'h000).
REQ-012 ir_hold  output  1  high suppresses the IR load on this clock.
REQ-013 sleeping  output  1  core in SLEEP state.

Function
REQ-014 An instruction cycle SHALL be four clocks; q_phase SHALL advance 0->1->2->3->0 every clock except in SLEEP.
REQ-015 States: STARTUP, EXEC, FLUSH, SLEEP; STARTUP SHALL last STARTUP_CYCLES full cycles with ir_skip high at each Q4, then transition to EXEC at Q1.
REQ-016 In EXEC, pc_inc SHALL pulse one clock at Q1; ir_hold SHALL be high at Q1-Q3 and low at Q4; the IR loads only at Q4.
REQ-017 imm_oe SHALL be high during Q2-Q3 when inst[11:8] is 1000 (RETLW), 1001 (CALL) or 11xx (literal ops), and low otherwise, including in FLUSH, STARTUP and SLEEP.
REQ-018 GOTO (101x), CALL (1001) and RETLW (1000) SHALL pulse pc_load at Q4 and ir_skip at Q4, then enter FLUSH.
REQ-019 Skip ops are BTFSC 0110, BTFSS 0111, DECFSZ 0010_11 and INCFSZ 0011_11 (inst[11:6]). skip_cond SHALL be sampled at Q3; if it is 1, ir_skip SHALL pulse at Q4 and the state SHALL be FLUSH, otherwise EXEC.
REQ-020 FLUSH SHALL execute the NOP for one cycle as in EXEC: pc_inc at Q1, no pc_load, no skip evaluation. It returns to EXEC at the next Q1.
REQ-021 ir_skip and pc_load SHALL never be asserted outside Q4.
REQ-022 inst is decoded only in EXEC; the contents of the flushed slot SHALL have no effect.

Reset
REQ-023 On reset assertion, regardless of phase, outputs SHALL immediately become q_phase=0, ir_skip=0, ir_hold=1, pc_inc=0, pc_load=0, imm_oe=0, sleeping=0, and the state SHALL be STARTUP with the startup counter cleared.
REQ-024 After reset release, the first clock SHALL be Q1 of startup cycle 0.

Configuration
REQ-025 Macro INST_SEQ_CTRL_SLEEP_EN: when defined, SLEEP (12'h003) in EXEC SHALL complete its cycle and then enter SLEEP at the next Q1. In SLEEP: q_phase holds 0, sleeping=1, ir_hold=1, all strobes 0. With wake=1 sampled, the next clock SHALL be EXEC Q1 with sleeping=0.
REQ-026 Without INST_SEQ_CTRL_SLEEP_EN, 12'h003 SHALL behave as NOP, sleeping SHALL be tied 0, wake SHALL be ignored, and no SLEEP state logic SHALL be built.

Structure
REQ-027 Shared package inst_seq_pkg SHALL hold the state enum, the phase constants Q1-Q4 and the opcode match constants (GOTO, CALL, RETLW, skip ops, SLEEP, NOP).
REQ-028 One sub-module, q_phase_gen (2-bit phase counter with hold input), SHALL be instantiated.

Verification
REQ-029 Reset mid-Q3 -> all outputs at reset values within the same cycle. Release -> q_phase=0, then STARTUP_CYCLES=1 gives ir_skip=1 at clock 4 and pc_inc=1 at clock 5.
REQ-030 inst=12'hC5A (MOVLW) -> imm_oe high at Q2 and Q3 only, pc_inc at Q1, no pc_load, next state EXEC.
REQ-031 inst=12'hA10 (GOTO) -> pc_load=1 and ir_skip=1 at Q4. The next cycle is FLUSH with imm_oe=0 and pc_inc at Q1, then EXEC.
REQ-032 inst=12'h6E5 (BTFSC) with skip_cond=1 at Q3 -> ir_skip at Q4 and FLUSH. Repeat with skip_cond=0 -> no ir_skip and EXEC.
REQ-033 Back-to-back case: BTFSC taken with the flushed slot holding 12'hA10 -> no pc_load during FLUSH.
REQ-034 With INST_SEQ_CTRL_SLEEP_EN, inst=12'h003 -> sleeping=1 and q_phase frozen at 0 for 20 clocks. wake=1 -> EXEC Q1 with sleeping=0 on the next clock. Without the macro -> NOP cycle and sleeping stays 0.
